// File: rtl/bp_tournament_updater.sv
`default_nettype none
// ============================================================================
// Module   : bp_tournament_updater
// Brief    : Resolve-side update engine for the tournament branch predictor.
//            Queues resolved branches and serially read-modify-writes the
//            local history, local, global and choice tables.
// Revision : 1.0
// ============================================================================
module bp_tournament_updater #(
    parameter int unsigned VLEN                  = 64,
    parameter int unsigned LocalHistoryTableSize = 1024,
    parameter int unsigned LocalPredictorSize    = 1024,
    parameter int unsigned GlobalPredictorSize   = 1024,
    parameter int unsigned ChoicePredictorSize   = 1024,
    parameter int unsigned FifoDepth             = 4,
    localparam int unsigned LHT_W = $clog2(LocalHistoryTableSize),
    localparam int unsigned LH_W  = $clog2(LocalPredictorSize),
    localparam int unsigned GH_W  = $clog2(GlobalPredictorSize),
    localparam int unsigned CH_W  = $clog2(ChoicePredictorSize)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_bp_i,
    input  logic             res_valid_i,
    output logic             res_ready_o,
    input  logic [VLEN-1:0]  res_pc_i,
    input  logic             res_taken_i,
    input  logic [GH_W-1:0]  res_ghr_i,
    output logic [LHT_W-1:0] lht_addr_o,
    input  logic [LH_W-1:0]  lht_rdata_i,
    output logic             lht_we_o,
    output logic [LH_W-1:0]  lht_wdata_o,
    output logic [LH_W-1:0]  lp_addr_o,
    input  logic [1:0]       lp_rdata_i,
    output logic             lp_we_o,
    output logic [1:0]       lp_wdata_o,
    output logic [GH_W-1:0]  gp_addr_o,
    input  logic [1:0]       gp_rdata_i,
    output logic             gp_we_o,
    output logic [1:0]       gp_wdata_o,
    output logic [CH_W-1:0]  ch_addr_o,
    input  logic [1:0]       ch_rdata_i,
    output logic             ch_we_o,
    output logic [1:0]       ch_wdata_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = $clog2(FifoDepth);
    localparam int unsigned CNT_W = $clog2(FifoDepth + 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(FifoDepth);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(FifoDepth - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_LHT = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    // Only the LHT index is kept per entry; the remaining PC bits never matter.
    logic [LHT_W-1:0] r_fifo_idx   [FifoDepth];
    logic             r_fifo_taken [FifoDepth];
    logic [GH_W-1:0]  r_fifo_ghr   [FifoDepth];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LHT_W-1:0] r_idx;
    logic             r_taken;
    logic [GH_W-1:0]  r_ghr;
    logic [LH_W-1:0]  r_lh;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_lc;
    logic w_gc;
    logic w_unused;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [1:0] f_sat(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign w_full      = (r_count == C_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_push      = res_valid_i && !w_full && !flush_bp_i;
    assign w_pop       = (r_state == S_IDLE) && !w_empty && !flush_bp_i;
    assign res_ready_o = !w_full;
    assign busy_o      = !w_empty || (r_state != S_IDLE);
    assign w_unused    = ^{res_pc_i[VLEN-1:LHT_W+1], res_pc_i[0]};

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr]   <= res_pc_i[LHT_W:1];
            r_fifo_taken[r_wr_ptr] <= res_taken_i;
            r_fifo_ghr[r_wr_ptr]   <= res_ghr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_taken  <= 1'b0;
            r_ghr    <= '0;
            r_lh     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_bp_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                if (w_push && !w_pop) r_count <= r_count + 1'b1;
                else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            end
            if (w_pop) begin
                r_idx   <= r_fifo_idx[r_rd_ptr];
                r_taken <= r_fifo_taken[r_rd_ptr];
                r_ghr   <= r_fifo_ghr[r_rd_ptr];
            end
            if (r_state == S_RD_LHT) r_lh <= lht_rdata_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_pop) w_state_nxt = S_RD_LHT;
            S_RD_LHT: w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (flush_bp_i) w_state_nxt = S_IDLE;
    end

    // A predictor is "correct" when its counter direction matches the outcome.
    assign w_lc = (lp_rdata_i[1] == r_taken);
    assign w_gc = (gp_rdata_i[1] == r_taken);

    always_comb begin
        lht_addr_o  = '0;
        lp_addr_o   = '0;
        gp_addr_o   = '0;
        ch_addr_o   = '0;
        lht_we_o    = 1'b0;
        lp_we_o     = 1'b0;
        gp_we_o     = 1'b0;
        ch_we_o     = 1'b0;
        lht_wdata_o = '0;
        lp_wdata_o  = '0;
        gp_wdata_o  = '0;
        ch_wdata_o  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) lht_addr_o = r_fifo_idx[r_rd_ptr];
            end
            S_RD_LHT: begin
                lht_addr_o = r_idx;
                lp_addr_o  = lht_rdata_i;
                gp_addr_o  = r_ghr;
                ch_addr_o  = r_ghr[CH_W-1:0];
            end
            S_WRITE: begin
                lht_addr_o  = r_idx;
                lp_addr_o   = r_lh;
                gp_addr_o   = r_ghr;
                ch_addr_o   = r_ghr[CH_W-1:0];
                lht_we_o    = !flush_bp_i;
                lp_we_o     = !flush_bp_i;
                gp_we_o     = !flush_bp_i;
                ch_we_o     = !flush_bp_i;
                lht_wdata_o = {r_lh[LH_W-2:0], r_taken};
                lp_wdata_o  = f_sat(lp_rdata_i, r_taken);
                gp_wdata_o  = f_sat(gp_rdata_i, r_taken);
                if (w_gc && !w_lc)      ch_wdata_o = f_sat(ch_rdata_i, 1'b1);
                else if (w_lc && !w_gc) ch_wdata_o = f_sat(ch_rdata_i, 1'b0);
                else                    ch_wdata_o = ch_rdata_i;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
